// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: preset video modes and derived-timing helpers
// shared by the timing generator and its per-axis counters.
package vga_timing_pkg;

  localparam int AXW = 12;

  typedef logic [AXW-1:0] ax_t;

  typedef struct packed {
    ax_t  view;
    ax_t  front;
    ax_t  sync;
    ax_t  back;
    logic pol;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_PRESETS [4] = '{
    '{h: '{view: 12'd640, front: 12'd16, sync: 12'd96,
           back: 12'd48, pol: 1'b0},
      v: '{view: 12'd480, front: 12'd10, sync: 12'd2,
           back: 12'd33, pol: 1'b0}},
    '{h: '{view: 12'd426, front: 12'd38, sync: 12'd13,
           back: 12'd73, pol: 1'b1},
      v: '{view: 12'd720, front: 12'd5, sync: 12'd5,
           back: 12'd20, pol: 1'b1}},
    '{h: '{view: 12'd320, front: 12'd21, sync: 12'd34,
           back: 12'd55, pol: 1'b1},
      v: '{view: 12'd1080, front: 12'd3, sync: 12'd5,
           back: 12'd32, pol: 1'b1}},
    '{h: '{view: 12'd320, front: 12'd15, sync: 12'd8,
           back: 12'd25, pol: 1'b1},
      v: '{view: 12'd1080, front: 12'd4, sync: 12'd5,
           back: 12'd36, pol: 1'b1}}
  };

  function automatic ax_t axis_max(vga_axis_t a);
    return a.view + a.front + a.sync + a.back - 12'd1;
  endfunction

  function automatic ax_t sync_start(vga_axis_t a);
    return a.view + a.front;
  endfunction

  function automatic ax_t sync_end(vga_axis_t a);
    return a.view + a.front + a.sync;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: one timing axis (counter, sync and view decode).
// Ports: clk, reset, step (advance), cur_max (wrap point of the
// running mode), nxt_* (decode limits for the following cycle),
// pos, at_max (comb), sync/view (registered, aligned with pos).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  ax_t          cur_max,
  input  ax_t          nxt_view,
  input  ax_t          nxt_ss,
  input  ax_t          nxt_se,
  input  logic         nxt_pol,
  output logic [W-1:0] pos,
  output logic         at_max,
  output logic         sync,
  output logic         view
);

  localparam int CW = (W > AXW) ? W : AXW;

  logic [W-1:0]  nxt;
  logic [CW-1:0] nxt_x;
  logic          in_sync;

  assign at_max = CW'(pos) == CW'(cur_max);

  always_comb begin
    nxt = pos;
    if (step) nxt = at_max ? '0 : pos + W'(1);
  end

  // Decode the value pos takes next, so the registered
  // outputs line up with pos in the same cycle.
  assign nxt_x   = CW'(nxt);
  assign in_sync = (nxt_x >= CW'(nxt_ss)) &&
                   (nxt_x < CW'(nxt_se));

  always_ff @(posedge clk) begin
    if (reset) begin
      pos  <= '0;
      sync <= ~nxt_pol;
      view <= 1'b1;
    end else begin
      pos  <= nxt;
      sync <= in_sync ? nxt_pol : ~nxt_pol;
      view <= nxt_x < CW'(nxt_view);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: four-preset VGA timing with frame-aligned switch.
// Ports: clk, reset, mode_sel/mode_req in; mode_active, mode_pending,
// hpos, vpos, hmax, vmax, hsync, vsync, visible, line_start,
// frame_start out; frame_count only with VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_BITS     = 11,
  parameter int V_BITS     = 11,
  parameter int RESET_MODE = 0,
  parameter int FRAME_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode_sel,
  input  logic              mode_req,
  output logic [1:0]        mode_active,
  output logic              mode_pending,
  output logic [H_BITS-1:0] hpos,
  output logic [V_BITS-1:0] vpos,
  output logic              hmax,
  output logic              vmax,
  output logic              hsync,
  output logic              vsync,
  output logic              visible,
  output logic              line_start,
  output logic              frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [FRAME_BITS-1:0] frame_count
`endif
);

  localparam logic [1:0] RST_MODE = 2'(RESET_MODE);

  for (genvar i = 0; i < 4; i++) begin : g_chk
    if (int'(axis_max(VGA_PRESETS[i].h)) >= (1 << H_BITS))
    begin : g_h
      $error("preset %0d does not fit H_BITS", i);
    end
    if (int'(axis_max(VGA_PRESETS[i].v)) >= (1 << V_BITS))
    begin : g_v
      $error("preset %0d does not fit V_BITS", i);
    end
  end
  if (RESET_MODE < 0 || RESET_MODE > 3) begin : g_rm
    $error("RESET_MODE out of range");
  end
  if (FRAME_BITS < 1) begin : g_fb
    $error("FRAME_BITS must be positive");
  end

  logic [1:0] pend_mode;
  logic [1:0] mode_next;
  logic       wrap;
  logic       h_view;
  logic       v_view;

  assign wrap = hmax && vmax;

  // mode used from the next cycle on; a request on the wrap
  // cycle itself is newer than anything pending
  always_comb begin
    mode_next = mode_active;
    if (reset) mode_next = RST_MODE;
    else if (wrap && mode_req) mode_next = mode_sel;
    else if (wrap && mode_pending) mode_next = pend_mode;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_active  <= RST_MODE;
      mode_pending <= 1'b0;
      pend_mode    <= RST_MODE;
    end else begin
      mode_active <= mode_next;
      if (wrap) mode_pending <= 1'b0;
      else if (mode_req) mode_pending <= 1'b1;
      if (mode_req) pend_mode <= mode_sel;
    end
  end

  vga_axis_counter #(.W(H_BITS)) u_h (
    .clk     (clk),
    .reset   (reset),
    .step    (1'b1),
    .cur_max (axis_max(VGA_PRESETS[mode_active].h)),
    .nxt_view(VGA_PRESETS[mode_next].h.view),
    .nxt_ss  (sync_start(VGA_PRESETS[mode_next].h)),
    .nxt_se  (sync_end(VGA_PRESETS[mode_next].h)),
    .nxt_pol (VGA_PRESETS[mode_next].h.pol),
    .pos     (hpos),
    .at_max  (hmax),
    .sync    (hsync),
    .view    (h_view)
  );

  vga_axis_counter #(.W(V_BITS)) u_v (
    .clk     (clk),
    .reset   (reset),
    .step    (hmax),
    .cur_max (axis_max(VGA_PRESETS[mode_active].v)),
    .nxt_view(VGA_PRESETS[mode_next].v.view),
    .nxt_ss  (sync_start(VGA_PRESETS[mode_next].v)),
    .nxt_se  (sync_end(VGA_PRESETS[mode_next].v)),
    .nxt_pol (VGA_PRESETS[mode_next].v.pol),
    .pos     (vpos),
    .at_max  (vmax),
    .sync    (vsync),
    .view    (v_view)
  );

  assign visible     = h_view && v_view;
  assign line_start  = hpos == '0;
  assign frame_start = line_start && (vpos == '0);

`ifdef VGA_TIMING_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) frame_count <= '0;
    else if (wrap) frame_count <= frame_count + FRAME_BITS'(1);
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random/directed mode requests, scoreboarded
// against an arithmetic model of the preset timings.
module tb_vga_timing_gen;

  localparam int FB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode_sel;
  logic        mode_req;
  logic [1:0]  mode_active;
  logic        mode_pending;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic        hmax, vmax, hsync, vsync, visible;
  logic        line_start, frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [FB-1:0] frame_count;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_BITS(11), .V_BITS(11), .RESET_MODE(0), .FRAME_BITS(FB)
  ) dut (
    .clk(clk), .reset(reset),
    .mode_sel(mode_sel), .mode_req(mode_req),
    .mode_active(mode_active), .mode_pending(mode_pending),
    .hpos(hpos), .vpos(vpos), .hmax(hmax), .vmax(vmax),
    .hsync(hsync), .vsync(vsync), .visible(visible),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  typedef struct packed {
    logic [1:0]  ma;
    logic        mp;
    logic [10:0] h;
    logic [10:0] v;
    logic        hm, vm, hs, vs, vis, ls, fs;
    logic [1:0]  fc;
  } obs_t;

  int hv[4] = '{640, 426, 320, 320};
  int hf[4] = '{16, 38, 21, 15};
  int hs[4] = '{96, 13, 34, 8};
  int hb[4] = '{48, 73, 55, 25};
  int vv[4] = '{480, 720, 1080, 1080};
  int vf[4] = '{10, 5, 3, 4};
  int vs[4] = '{2, 5, 5, 5};
  int vb[4] = '{33, 20, 32, 36};
  bit pl[4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  int mx, my, mmode, mpm, mfc;
  bit mpend;

  obs_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   ncyc   = 0;
  bit   abort  = 0;

  function automatic int htot(int m);
    return hv[m] + hf[m] + hs[m] + hb[m];
  endfunction

  function automatic int vtot(int m);
    return vv[m] + vf[m] + vs[m] + vb[m];
  endfunction

  task automatic model_step(bit r, bit q, int s);
    bit last_px;
    if (r) begin
      mx = 0; my = 0; mmode = 0; mpend = 0; mfc = 0;
      return;
    end
    last_px = (mx == htot(mmode) - 1) && (my == vtot(mmode) - 1);
    if (q) begin
      mpend = 1; mpm = s;
    end
    if (last_px) begin
      if (mpend) mmode = mpm;
      mpend = 0; mx = 0; my = 0;
      mfc = (mfc + 1) % (1 << FB);
    end else if (mx == htot(mmode) - 1) begin
      mx = 0; my++;
    end else begin
      mx++;
    end
  endtask

  function automatic obs_t expect_now();
    obs_t e;
    int   m;
    m     = mmode;
    e.ma  = 2'(m);
    e.mp  = mpend;
    e.h   = 11'(mx);
    e.v   = 11'(my);
    e.hm  = mx == htot(m) - 1;
    e.vm  = my == vtot(m) - 1;
    e.hs  = (mx >= hv[m] + hf[m] && mx < hv[m] + hf[m] + hs[m])
            ? pl[m] : !pl[m];
    e.vs  = (my >= vv[m] + vf[m] && my < vv[m] + vf[m] + vs[m])
            ? pl[m] : !pl[m];
    e.vis = mx < hv[m] && my < vv[m];
    e.ls  = mx == 0;
    e.fs  = mx == 0 && my == 0;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    e.fc  = 2'(mfc);
`else
    e.fc  = 2'd0;
`endif
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t a;
    a.ma  = mode_active;
    a.mp  = mode_pending;
    a.h   = hpos;
    a.v   = vpos;
    a.hm  = hmax;
    a.vm  = vmax;
    a.hs  = hsync;
    a.vs  = vsync;
    a.vis = visible;
    a.ls  = line_start;
    a.fs  = frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    a.fc  = frame_count;
`else
    a.fc  = 2'd0;
`endif
    return a;
  endfunction

  task automatic note_fail();
    if (total - passed >= 20) abort = 1;
  endtask

  task automatic chk(string n, int got, int want);
    total++;
    if (got == want) passed++;
    else begin
      $display("FAIL %s: got %0d want %0d", n, got, want);
      note_fail();
    end
  endtask

  // monitor: one scoreboard entry per clocked cycle
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = observe();
        total++;
        if (a === e) passed++;
        else begin
          $display({"FAIL obs cyc=%0d got m=%0d p=%0d (%0d,%0d) ",
                    "f=%b want m=%0d p=%0d (%0d,%0d) f=%b"},
                   ncyc, a.ma, a.mp, a.h, a.v,
                   {a.hm, a.vm, a.hs, a.vs, a.vis, a.ls, a.fs, a.fc},
                   e.ma, e.mp, e.h, e.v,
                   {e.hm, e.vm, e.hs, e.vs, e.vis, e.ls, e.fs, e.fc});
          note_fail();
        end
      end
    end
  end

  task automatic cyc(bit r, bit q, logic [1:0] s);
    reset    = r;
    mode_req = q;
    mode_sel = s;
    @(posedge clk);
    model_step(r, q, int'(s));
    sb.push_back(expect_now());
    ncyc++;
    @(negedge clk);
  endtask

  initial begin
    bit         q;
    logic [1:0] s;
    int         rx, ry;
    reset = 1'b1; mode_req = 1'b0; mode_sel = 2'd0;
    mx = 0; my = 0; mmode = 0; mpm = 0; mfc = 0; mpend = 0;
    @(negedge clk);
    repeat (3) cyc(1, 0, 2'd0);

    // frame 0 (mode 0): requests 1, random, then 3 last
    rx = $urandom_range(0, 799);
    ry = $urandom_range(101, 299);
    while (!abort && mfc == 0) begin
      q = 0; s = 2'd0;
      if (mx == 0 && my == 100) begin
        q = 1; s = 2'd1;
      end else if (mx == rx && my == ry) begin
        q = 1; s = 2'($urandom_range(0, 3));
      end else if (mx == 0 && my == 300) begin
        q = 1; s = 2'd3;
      end
      cyc(0, q, s);
    end
    chk("last_wins_mode", int'(mode_active), 3);
    chk("last_wins_pending", int'(mode_pending), 0);

    // frame 1 (mode 3): random early request, then 1 on wrap
    while (!abort && mfc == 1) begin
      q = 0; s = 2'd0;
      if (mx == 17 && my == 500) begin
        q = 1; s = 2'($urandom_range(0, 3));
      end else if (mx == htot(mmode) - 1 &&
                   my == vtot(mmode) - 1) begin
        q = 1; s = 2'd1;
      end
      cyc(0, q, s);
    end
    chk("wrap_req_mode", int'(mode_active), 1);
    chk("wrap_req_pending", int'(mode_pending), 0);

    // frame 2 (mode 1): pending request, then reset at (300,200)
    while (!abort && !(mx == 300 && my == 200)) begin
      q = (mx == 0 && my == 100);
      s = 2'($urandom_range(0, 3));
      cyc(0, q, s);
    end
    chk("pre_reset_pending", int'(mode_pending), 1);
    cyc(1, 0, 2'd2);
    chk("reset_frame_start", int'(frame_start), 1);
    chk("reset_mode", int'(mode_active), 0);
    chk("reset_pending", int'(mode_pending), 0);

    // random request traffic
    for (int i = 0; i < 3000 && !abort; i++) begin
      q = $urandom_range(0, 99) == 0;
      s = 2'($urandom_range(0, 3));
      cyc(0, q, s);
    end
    mode_req = 1'b0;

    repeat (2) @(negedge clk);
    chk("queue_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Multi-mode VGA/HDMI-adapter timing generator. It produces pixel counters, sync pulses, the display-enable signal and line/frame strobes for one of four preset video modes. The active mode is selected at runtime and switched only at a frame boundary. It sits between the pixel clock domain root and the pixel/ROM-fetch pipeline, and is the parametrised successor of the fixed-timing sync block.

## Interface
Parameters:
- `H_BITS`, default 11: width of `hpos`.
- `V_BITS`, default 11: width of `vpos`.
- `RESET_MODE`, default 0: preset index loaded on reset (0..3).
- `FRAME_BITS`, default 8: width of `frame_count`. Used only with `VGA_TIMING_FRAME_COUNT_EN`.

Ports:
- `clk`, in, 1: pixel clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high.
- `mode_sel`, in, 2: requested preset index.
- `mode_req`, in, 1: one-cycle strobe; latches `mode_sel` as the pending mode.
- `mode_active`, out, 2: preset currently driving the timing.
- `mode_pending`, out, 1: a requested mode is waiting for the frame wrap.
- `hpos`, out, `H_BITS`: horizontal counter.
- `vpos`, out, `V_BITS`: vertical counter.
- `hmax`, out, 1: `hpos` equals `H_MAX` of the active mode (combinational from regs).
- `vmax`, out, 1: `vpos` equals `V_MAX` of the active mode (combinational from regs).
- `hsync`, out, 1: horizontal sync at the active mode's polarity, registered.
- `vsync`, out, 1: vertical sync at the active mode's polarity, registered.
- `visible`, out, 1: display enable, registered.
- `line_start`, out, 1: high while `hpos` = 0.
- `frame_start`, out, 1: high while `hpos` = 0 and `vpos` = 0.
- `frame_count`, out, `FRAME_BITS`: present only with the macro.

## Operation
Presets, listed as H view/front/sync/back, V view/front/sync/back, then polarity:
- Mode 0: H 640/16/96/48, V 480/10/2/33, negative/negative.
- Mode 1: H 426/38/13/73, V 720/5/5/20, positive/positive.
- Mode 2: H 320/21/34/55, V 1080/3/5/32, positive/positive.
- Mode 3: H 320/15/8/25, V 1080/4/5/36, positive/positive.

Derived values:
- `H_MAX` = sum of H fields − 1. `V_MAX` = sum of V fields − 1.
- `SYNC_START` = VIEW + FRONT. `SYNC_END` = `SYNC_START` + SYNC.

Counters:
- `hpos` increments every cycle and wraps to 0 after `H_MAX`.
- `vpos` increments on `hmax` and wraps to 0 on `hmax` && `vmax`.

Decoded outputs are registered from the next counter state, so they are aligned with the `hpos`/`vpos` seen in the same cycle:
- `hsync` is at the active level iff `SYNC_START` ≤ `hpos` < `SYNC_END`.
- `vsync` is at the active level iff `V_SYNC_START` ≤ `vpos` < `V_SYNC_END`.
- `visible` = (`hpos` < H_VIEW) && (`vpos` < V_VIEW).

Mode switching:
- `mode_req` latches `mode_sel` into the pending register and sets `mode_pending`.
- A later request before the wrap overwrites the pending mode; the last request wins.
- On the wrap cycle (`hmax` && `vmax`), a pending mode becomes `mode_active` and `mode_pending` clears. The first cycle of the new frame (0,0) already uses the new timing and polarity.
- A `mode_req` sampled on the wrap cycle itself applies at that same wrap.
- Requesting the currently active mode is legal. It causes no timing change; `mode_pending` clears at the wrap.

Reset values:
- `hpos` = 0, `vpos` = 0, `mode_active` = `RESET_MODE`, `mode_pending` = 0, `frame_count` = 0.
- `hsync`/`vsync` at the inactive level of `RESET_MODE`.
- `visible` = 1, `line_start` = 1, `frame_start` = 1, consistent with position (0,0), which is visible in every preset.

Reset mid-frame discards any pending request.

## Timing
- Latency: the counter wrap and all decoded outputs change on the same clock edge; there is no pipeline skew between `hpos` and `hsync`/`visible`.
- Line length is `H_MAX`+1 cycles. Frame length is (`H_MAX`+1)(`V_MAX`+1) cycles.
- Mode change latency: between 1 cycle and one full frame after `mode_req`.
- `frame_count` increments on the wrap edge, so it reads the new value at `frame_start`. It wraps modulo 2^`FRAME_BITS`.

## Configuration
- Macro: `VGA_TIMING_FRAME_COUNT_EN`.
- Defined: the `frame_count` port and its counter exist.
- Undefined: the port and its logic are absent, and `FRAME_BITS` is ignored.

## Structure
- Package `vga_timing_pkg` holds:
  - typedef `vga_axis_t` with fields `view`, `front`, `sync`, `back`, `pol`;
  - typedef `vga_mode_t` with fields `h` and `v`;
  - localparam array `VGA_PRESETS[4]`;
  - function helpers for MAX, SYNC_START and SYNC_END.
- Sub-module `vga_axis_counter` is instantiated twice (H and V). It contains the counter with enable and wrap, the sync and view decode, and the registered outputs.
- The top level holds the mode and pending registers, the strobes and the frame counter.
- Elaboration asserts that every preset fits in `H_BITS`/`V_BITS`.

## Test plan
1. **Reset default:** reset with `RESET_MODE`=0. Require `hsync`=0 exactly for `hpos` 656..751, line length 800, `vsync`=0 for `vpos` 490..491, frame length 525 lines, `visible` for `hpos`<640 && `vpos`<480.
2. **Mid-frame switch:** `mode_req` with `mode_sel`=1 at `vpos`=100. Require `mode_pending`=1 and unchanged mode-0 timing until (799,524). The next cycle is (0,0) with `mode_active`=1. The line is then 550 cycles with `hsync`=1 for `hpos` 464..476.
3. **Last request wins:** request 2, then request 3 before the wrap. Require `mode_active`=3 after the wrap, line length 368, `vsync` high for `vpos` 1084..1088.
4. **Request on wrap:** `mode_req` asserted on the `hmax`&&`vmax` cycle. Require the new mode at the very next (0,0) and `mode_pending` to stay 0.
5. **Reset mid-frame:** reset at (300,200) in mode 1 with a pending request. The next cycle requires (0,0), `mode_active`=`RESET_MODE`, `mode_pending`=0 and `frame_start`=1.
6. **Frame counter:** with the macro defined and `FRAME_BITS`=2, run 5 frames. Require `frame_count` at each `frame_start` to read 0,1,2,3,0,1.
